// File: rtl/dram_master_if.sv
// Request/response and RAM pin bundle for dram_master.
// master: the dram_master side. slave: the MEM stage plus data RAM side.
interface dram_master_if;
    // MEM-stage request/response
    logic        req_valid_i;
    logic        req_ready_o;
    logic [2:0]  req_op_i;
    logic [31:0] req_addr_i;
    logic [31:0] req_wdata_i;
    logic        resp_valid_o;
    logic [31:0] rdata_o;
    logic        exc_o;
    logic [1:0]  exc_code_o;
    // data RAM pins
    logic        ram_ce_o;
    logic        ram_we_o;
    logic [3:0]  ram_sel_o;
    logic [31:0] ram_addr_o;
    logic [31:0] ram_data_o;
    logic [31:0] ram_data_i;

    modport master (
        input  req_valid_i, req_op_i, req_addr_i, req_wdata_i, ram_data_i,
        output req_ready_o, resp_valid_o, rdata_o, exc_o, exc_code_o,
               ram_ce_o, ram_we_o, ram_sel_o, ram_addr_o, ram_data_o
    );

    modport slave (
        output req_valid_i, req_op_i, req_addr_i, req_wdata_i, ram_data_i,
        input  req_ready_o, resp_valid_o, rdata_o, exc_o, exc_code_o,
               ram_ce_o, ram_we_o, ram_sel_o, ram_addr_o, ram_data_o
    );
endinterface

// File: rtl/dram_master.sv
// Load/store initiator between the MEM stage and a synchronous-write,
// combinational-read data RAM. Big-endian lanes: byte offset 0 -> [31:24].
// Optional macro DRAM_ALIGN_CHK_EN: misaligned half/word accesses raise
// exceptions; without it the low address bits are forced to alignment.
module dram_master #(
    parameter int          DMEM_AW    = 10,
    parameter logic [31:0] RESET_DATA = 32'h0
) (
    input logic           clk,
    input logic           rst,
    dram_master_if.master bus
);
    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    // access size: 0 = byte, 1 = half, 2 = word
    function automatic logic [1:0] op_size(input logic [2:0] op);
        case (op)
            3'd0, 3'd1, 3'd5: op_size = 2'd0;
            3'd2, 3'd3, 3'd6: op_size = 2'd1;
            default:          op_size = 2'd2;
        endcase
    endfunction

    state_t      state, state_nxt;
    logic [2:0]  op_q;
    logic [31:0] addr_q, wdata_q, rdata_q;
    logic        exc_q;
    logic [1:0]  code_q;

    logic        accept;
    logic [1:0]  in_size, q_size;
    logic        in_store, q_store;
    logic [31:0] addr_eff;
    logic [1:0]  code_chk;
    logic [7:0]  lane_b;
    logic [15:0] lane_h;
    logic [31:0] load_ext;

    assign accept   = (state == IDLE) && bus.req_valid_i;
    assign in_size  = op_size(bus.req_op_i);
    assign in_store = bus.req_op_i >= 3'd5;
    assign q_size   = op_size(op_q);
    assign q_store  = op_q >= 3'd5;

    // Address checks on the incoming request; out of range beats misaligned
    always_comb begin
        logic oor;
        oor      = (bus.req_addr_i >> (DMEM_AW + 2)) != 32'd0;
        addr_eff = bus.req_addr_i;
        code_chk = oor ? 2'd3 : 2'd0;
`ifdef DRAM_ALIGN_CHK_EN
        if (!oor && ((in_size == 2'd1 && bus.req_addr_i[0]) ||
                     (in_size == 2'd2 && bus.req_addr_i[1:0] != 2'b00)))
            code_chk = in_store ? 2'd2 : 2'd1;
`else
        if (in_size == 2'd1) addr_eff[0]   = 1'b0;
        if (in_size == 2'd2) addr_eff[1:0] = 2'b00;
`endif
    end

    // Pick the addressed lane out of the RAM word and extend it
    always_comb begin
        case (addr_q[1:0])
            2'd0:    lane_b = bus.ram_data_i[31:24];
            2'd1:    lane_b = bus.ram_data_i[23:16];
            2'd2:    lane_b = bus.ram_data_i[15:8];
            default: lane_b = bus.ram_data_i[7:0];
        endcase
        lane_h = addr_q[1] ? bus.ram_data_i[15:0] : bus.ram_data_i[31:16];
        case (op_q)
            3'd0:    load_ext = {{24{lane_b[7]}}, lane_b};
            3'd1:    load_ext = {24'd0, lane_b};
            3'd2:    load_ext = {{16{lane_h[15]}}, lane_h};
            3'd3:    load_ext = {16'd0, lane_h};
            default: load_ext = bus.ram_data_i;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    // Request latch and load-data register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            op_q    <= 3'd0;
            addr_q  <= 32'd0;
            wdata_q <= 32'd0;
            exc_q   <= 1'b0;
            code_q  <= 2'd0;
            rdata_q <= RESET_DATA;
        end else begin
            if (accept) begin
                op_q    <= bus.req_op_i;
                addr_q  <= addr_eff;
                wdata_q <= bus.req_wdata_i;
                exc_q   <= code_chk != 2'd0;
                code_q  <= code_chk;
            end
            if (state == ACCESS && !q_store) rdata_q <= load_ext;
        end
    end

    // Next state and RAM/handshake outputs; RAM pins only live in ACCESS
    always_comb begin
        state_nxt        = state;
        bus.req_ready_o  = 1'b0;
        bus.resp_valid_o = 1'b0;
        bus.exc_o        = 1'b0;
        bus.exc_code_o   = 2'd0;
        bus.ram_ce_o     = 1'b0;
        bus.ram_we_o     = 1'b0;
        bus.ram_sel_o    = 4'b0000;
        bus.ram_addr_o   = 32'd0;
        bus.ram_data_o   = 32'd0;
        bus.rdata_o      = rdata_q;
        case (state)
            IDLE: begin
                bus.req_ready_o = rst;
                if (bus.req_valid_i)
                    state_nxt = (code_chk != 2'd0) ? RESP : ACCESS;
            end
            ACCESS: begin
                bus.ram_ce_o   = 1'b1;
                bus.ram_we_o   = q_store;
                bus.ram_addr_o = {addr_q[31:2], 2'b00};
                case (q_size)
                    2'd0:    bus.ram_sel_o = 4'b1000 >> addr_q[1:0];
                    2'd1:    bus.ram_sel_o = addr_q[1] ? 4'b0011 : 4'b1100;
                    default: bus.ram_sel_o = 4'b1111;
                endcase
                if (q_store) begin
                    case (q_size)
                        2'd0:    bus.ram_data_o = {4{wdata_q[7:0]}};
                        2'd1:    bus.ram_data_o = {2{wdata_q[15:0]}};
                        default: bus.ram_data_o = wdata_q;
                    endcase
                end
                state_nxt = RESP;
            end
            RESP: begin
                bus.resp_valid_o = 1'b1;
                bus.exc_o        = exc_q;
                bus.exc_code_o   = code_q;
                state_nxt        = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end
endmodule

// File: tb/tb_dram_master.sv
// Self-checking bench for dram_master: directed steps followed by random
// loads/stores, checked against a byte-addressed big-endian memory model.
module tb_dram_master;
    localparam int          AW        = 10;
    localparam logic [31:0] RST_DATA  = 32'h0;
    localparam int          NBYTES    = 4 << AW;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic ram_clr = 1'b1;
    always #5 clk = ~clk;

    dram_master_if bus ();

    dram_master #(.DMEM_AW(AW), .RESET_DATA(RST_DATA)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // attached RAM: synchronous byte-lane write, combinational read
    logic [31:0] ram [0:(1<<AW)-1];
    assign bus.ram_data_i = ram[bus.ram_addr_o[AW+1:2]];
    always @(posedge clk) begin
        if (ram_clr) begin
            for (int i = 0; i < (1<<AW); i++) ram[i] <= 32'd0;
        end else if (bus.ram_ce_o && bus.ram_we_o) begin
            for (int l = 0; l < 4; l++)
                if (bus.ram_sel_o[l])
                    ram[bus.ram_addr_o[AW+1:2]][l*8 +: 8] <= bus.ram_data_o[l*8 +: 8];
        end
    end

    // reference model: flat byte memory, byte address a holds the MSB first
    logic [7:0]  mem [0:NBYTES-1];
    logic [31:0] last_rd;
    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] model_word(input int w);
        return {mem[4*w], mem[4*w+1], mem[4*w+2], mem[4*w+3]};
    endfunction

    // One request, starting and ending at a negedge with the DUT idle
    task automatic xact(input logic [2:0] op, input logic [31:0] addr, input logic [31:0] wd);
        int          n;
        logic        st, sgn;
        logic [31:0] ea, ed, erd;
        logic [1:0]  ec;
        logic [3:0]  es;
        logic        oor, mis;
        n   = (op == 3'd0 || op == 3'd1 || op == 3'd5) ? 1 :
              (op == 3'd2 || op == 3'd3 || op == 3'd6) ? 2 : 4;
        st  = op >= 3'd5;
        sgn = (op == 3'd0 || op == 3'd2);
        oor = addr >= NBYTES;
        mis = (n == 2 && addr[0]) || (n == 4 && addr[1:0] != 2'b00);
        ea  = addr;
`ifdef DRAM_ALIGN_CHK_EN
        ec = oor ? 2'd3 : (mis ? (st ? 2'd2 : 2'd1) : 2'd0);
`else
        ec = oor ? 2'd3 : 2'd0;
        if (n == 2) ea[0] = 1'b0;
        if (n == 4) ea[1:0] = 2'b00;
`endif
        es = 4'b0000;
        for (int i = 0; i < n; i++) es[3 - (ea[1:0] + i)] = 1'b1;
        ed = (n == 1) ? {4{wd[7:0]}} : (n == 2) ? {2{wd[15:0]}} : wd;
        erd = 32'd0;
        if (ec == 2'd0 && !st) begin
            for (int i = 0; i < n; i++) erd = {erd[23:0], mem[ea + i]};
            if (sgn && n == 1) erd = {{24{erd[7]}}, erd[7:0]};
            if (sgn && n == 2) erd = {{16{erd[15]}}, erd[15:0]};
        end

        chk("ready_idle", bus.req_ready_o, 1);
        bus.req_valid_i = 1'b1;
        bus.req_op_i    = op;
        bus.req_addr_i  = addr;
        bus.req_wdata_i = wd;
        @(negedge clk);
        bus.req_valid_i = 1'b0;
        if (ec != 2'd0) begin
            chk("exc_resp", bus.resp_valid_o, 1);
            chk("exc_flag", bus.exc_o, 1);
            chk("exc_code", bus.exc_code_o, ec);
            chk("exc_no_ce", bus.ram_ce_o, 0);
            chk("exc_rdata", bus.rdata_o, last_rd);
        end else begin
            chk("acc_ce", bus.ram_ce_o, 1);
            chk("acc_we", bus.ram_we_o, st);
            chk("acc_sel", bus.ram_sel_o, es);
            chk("acc_addr", bus.ram_addr_o, {ea[31:2], 2'b00});
            if (st) chk("acc_data", bus.ram_data_o, ed);
            chk("acc_no_resp", bus.resp_valid_o, 0);
            @(negedge clk);
            chk("resp_valid", bus.resp_valid_o, 1);
            chk("resp_exc", bus.exc_o, 0);
            chk("resp_ce_off", bus.ram_ce_o, 0);
            if (!st) last_rd = erd;
            chk("resp_rdata", bus.rdata_o, last_rd);
            if (st) for (int i = 0; i < n; i++) mem[ea + i] = 8'(wd >> (8 * (n - 1 - i)));
        end
        @(negedge clk);
        chk("resp_done", bus.resp_valid_o, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int idx [$];
        int cyc;
        logic [2:0]  rop;
        logic [31:0] raddr;

        for (int i = 0; i < NBYTES; i++) mem[i] = 8'd0;
        last_rd = RST_DATA;
        bus.req_valid_i = 1'b0;
        bus.req_op_i    = 3'd0;
        bus.req_addr_i  = 32'd0;
        bus.req_wdata_i = 32'd0;

        // reset state
        repeat (3) @(negedge clk);
        chk("rst_ready", bus.req_ready_o, 0);
        chk("rst_resp", bus.resp_valid_o, 0);
        chk("rst_ce", bus.ram_ce_o, 0);
        chk("rst_rdata", bus.rdata_o, RST_DATA);
        ram_clr = 1'b0;
        rst = 1'b1;
        @(negedge clk);

        // directed steps
        xact(3'd7, 32'h10, 32'hA1B2C3D4);   // SW
        xact(3'd4, 32'h10, 32'h0);          // LW
        xact(3'd5, 32'h21, 32'h000000F0);   // SB
        xact(3'd0, 32'h21, 32'h0);          // LB
        xact(3'd1, 32'h21, 32'h0);          // LBU
        xact(3'd6, 32'h32, 32'h00008001);   // SH
        xact(3'd2, 32'h32, 32'h0);          // LH
        xact(3'd3, 32'h30, 32'h0);          // LHU
        xact(3'd4, 32'h13, 32'h0);          // misaligned LW
        xact(3'd6, 32'h31, 32'h00001234);   // misaligned SH
        xact(3'd7, 32'h00001000, 32'h55AA55AA); // out of range
        chk("oor_ram0", ram[0], model_word(0));
        chk("oor_ram4", ram[4], model_word(4));

        // reset during the ACCESS cycle of a store
        bus.req_valid_i = 1'b1;
        bus.req_op_i    = 3'd7;
        bus.req_addr_i  = 32'h40;
        bus.req_wdata_i = 32'hDEADBEEF;
        @(negedge clk);
        bus.req_valid_i = 1'b0;
        chk("mid_ce", bus.ram_ce_o, 1);
        chk("mid_we", bus.ram_we_o, 1);
        rst = 1'b0;
        #1;
        chk("mid_we_drop", bus.ram_we_o, 0);
        chk("mid_ce_drop", bus.ram_ce_o, 0);
        chk("mid_ready", bus.req_ready_o, 0);
        @(negedge clk);
        chk("mid_no_resp", bus.resp_valid_o, 0);
        chk("mid_rdata", bus.rdata_o, RST_DATA);
        last_rd = RST_DATA;
        rst = 1'b1;
        #1;
        chk("post_ready", bus.req_ready_o, 1);
        chk("mid_ram", ram[16], model_word(16));
        @(negedge clk);

        // back-to-back loads with valid held high
        xact(3'd7, 32'h50, 32'h13572468);
        bus.req_valid_i = 1'b1;
        bus.req_op_i    = 3'd4;
        bus.req_addr_i  = 32'h50;
        for (cyc = 1; cyc <= 12; cyc++) begin
            @(negedge clk);
            if (bus.resp_valid_o) begin
                idx.push_back(cyc);
                chk("b2b_rdata", bus.rdata_o, model_word(20));
                if (idx.size() == 2) break;
            end
        end
        bus.req_valid_i = 1'b0;
        chk("b2b_count", idx.size(), 2);
        if (idx.size() == 2) chk("b2b_gap", idx[1] - idx[0], 3);
        last_rd = model_word(20);
        @(negedge clk);

        // random traffic
        for (int t = 0; t < 300; t++) begin
            rop   = 3'($urandom_range(0, 7));
            raddr = ($urandom_range(0, 15) == 0) ? ($urandom | 32'h1000)
                                                 : 32'($urandom_range(0, 255));
            xact(rop, raddr, $urandom);
        end

        // final RAM image against model
        for (int w = 0; w < (1<<AW); w++)
            if (ram[w] !== model_word(w)) chk("ram_final", ram[w], model_word(w));
        chk("ram_w4", ram[4], model_word(4));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/dram_master.md
Name: dram_master

Overview:
- Load/store initiator between the MEM pipeline stage and the synchronous-write, combinational-read data RAM.
- Accepts one load or store request at a time over a valid/ready handshake.
- Drives the RAM's ce/we/sel/addr/data pins using big-endian byte lanes: byte offset 0 maps to lane [31:24].
- Extracts and sign- or zero-extends load data, flags misaligned and out-of-range accesses, and returns a one-cycle response pulse.

Parameters:
- DMEM_AW, 10, word-index width of the attached RAM; a valid byte address satisfies addr[31:DMEM_AW+2]==0.
- RESET_DATA, 32'h0, value of rdata_o after reset.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-low reset (0 = reset).
- req_valid_i  input  1  request present.
- req_ready_o  output  1  block can accept a request.
- req_op_i  input  3  0=LB 1=LBU 2=LH 3=LHU 4=LW 5=SB 6=SH 7=SW.
- req_addr_i  input  32  byte address.
- req_wdata_i  input  32  store data, right-justified.
- resp_valid_o  output  1  one-cycle response pulse.
- rdata_o  output  32  extended load data; holds until the next load response.
- exc_o  output  1  valid with resp_valid_o: 1 = access rejected.
- exc_code_o  output  2  0=none 1=misaligned load 2=misaligned store 3=out of range.
- ram_ce_o  output  1  RAM chip enable.
- ram_we_o  output  1  RAM write enable.
- ram_sel_o  output  4  byte lane enables; [3] selects the lowest address.
- ram_addr_o  output  32  word-aligned address; bits [1:0] are always 0.
- ram_data_o  output  32  write data, replicated into the target lane.
- ram_data_i  input  32  combinational RAM read data.

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE; req_ready_o=0 while rst=0; all other outputs 0; rdata_o=RESET_DATA.
- Reset mid-operation: ram_ce_o and ram_we_o drop immediately, so no RAM write occurs; the in-flight request is lost with no response.
- FSM has three states: IDLE, ACCESS, RESP.
- IDLE: req_ready_o=1.
  - On a rising edge with req_valid_i=1, latch op, addr and wdata.
  - If the latched access fails a check, go to RESP with the exception flag set.
  - Otherwise go to ACCESS.
- ACCESS (exactly one cycle): ram_ce_o=1; ram_addr_o={addr[31:2],2'b00}; ram_we_o=1 only for stores.
  - Lane selection from addr[1:0]:
    - Byte ops: sel = 4'b1000 >> addr[1:0].
    - Half ops: sel = 4'b1100 for offset 0, 4'b0011 for offset 2.
    - Word ops: sel = 4'b1111.
  - Store data: SB puts {4{wdata[7:0]}} on ram_data_o; SH puts {2{wdata[15:0]}}; SW puts wdata.
  - The RAM write commits on the edge that leaves ACCESS.
  - Loads register the extracted lane into rdata_o on that same edge. LB/LH sign-extend, LBU/LHU zero-extend.
- RESP: resp_valid_o=1 for exactly one cycle; exc_o and exc_code_o are valid. Next state is IDLE.
- Latency: accept at edge t0 -> ACCESS in cycle [t0,t1] -> resp_valid_o high in cycle [t1,t2] -> req_ready_o high again from t2. Throughput is one access per 3 cycles.
- Exceptions:
  - No RAM access occurs (ram_ce_o stays 0); resp_valid_o pulses one cycle after acceptance.
  - rdata_o keeps its previous value.
  - Out of range takes priority over misaligned.
- Outside ACCESS, ram_ce_o=0, ram_we_o=0, ram_sel_o=0, ram_addr_o=0 and ram_data_o=0.
- req_valid_i is ignored in ACCESS and RESP (req_ready_o=0 there). A request held valid across RESP is accepted on the first IDLE edge.

Optional Feature:
- Macro: DRAM_ALIGN_CHK_EN.
- Defined: misaligned accesses raise exceptions.
  - Half ops with addr[0]=1 are misaligned.
  - Word ops with addr[1:0]!=0 are misaligned.
  - Codes: 1 for loads, 2 for stores.
- Undefined: no alignment check.
  - Half ops force addr[0]=0; word ops force addr[1:0]=0.
  - Code 1 and code 2 are never produced.
- The out-of-range check is present in both builds.

Test Plan:
- SW addr 0x10, wdata 0xA1B2C3D4, then LW 0x10 -> ACCESS shows sel=4'b1111, addr=0x10; the load response returns rdata_o=0xA1B2C3D4, exc_o=0.
- SB addr 0x21, wdata 0x000000F0, over RAM word 0x00000000 -> sel=4'b0100, ram_data_o=0xF0F0F0F0. Then LB 0x21 -> rdata_o=0xFFFFFFF0; LBU 0x21 -> rdata_o=0x000000F0.
- SH addr 0x32, wdata 0x8001, then LH 0x32 -> sel=4'b0011, rdata_o=0xFFFF8001. LHU 0x30 -> upper half zero-extended.
- With DRAM_ALIGN_CHK_EN: LW 0x13 -> resp_valid_o one cycle after accept, exc_code_o=1, ram_ce_o never high, rdata_o unchanged. SH 0x31 -> exc_code_o=2. Without the macro: LW 0x13 reads word 0x10.
- DMEM_AW=10: SW addr 0x00001000 -> exc_code_o=3, no RAM write, and RAM contents are verified unchanged.
- Assert rst=0 during the ACCESS cycle of an SW -> ram_we_o drops immediately, the memory word is unchanged, and there is no response. After release, req_ready_o=1 and back-to-back LW requests show 3-cycle spacing.
